// File: rtl/operand_loader_pkg.sv
// Shared widths and field indices for the operand loader front end.
package operand_loader_pkg;

  localparam int OP_W   = 7;
  localparam int NIB_W  = 4;
  localparam int HI_W   = OP_W - NIB_W;
  localparam int NUM_PB = 4;

  // One button per operand field; the index doubles as the load_mask bit.
  localparam int FLD_A_LO = 0;
  localparam int FLD_A_HI = 1;
  localparam int FLD_B_LO = 2;
  localparam int FLD_B_HI = 3;

endpackage

// File: rtl/pb_debouncer.sv
// Single pushbutton conditioner: 2-flop synchronizer, hold-time debounce and
// a one-cycle strobe on each accepted press.
module pb_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press_pulse,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state here is sequential, so it is written with <= only; mixing
  // blocking assignments into clocked blocks creates simulation/synthesis races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      stable_q  <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      stable_q  <= stable;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Rising edge of the accepted level only; releases are silent.
  assign press_pulse = stable & ~stable_q;
  assign level       = stable;

endmodule

// File: rtl/operand_loader.sv
// Loads switch nibbles into the adder's 7-bit operands a and b under control
// of four debounced pushbuttons, and tracks when both operands are complete.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pb1,
  input  logic              pb2,
  input  logic              pb3,
  input  logic              pb4,
  input  logic [NIB_W-1:0]  y,
  input  logic              clr,
  output logic [OP_W-1:0]   a,
  output logic [OP_W-1:0]   b,
  output logic [NUM_PB-1:0] load_mask,
  output logic              operands_valid,
  output logic              upd
);

  logic [NUM_PB-1:0] pb_raw;
  logic [NUM_PB-1:0] strobe;
  logic [NUM_PB-1:0] unused_level;
  logic [NIB_W-1:0]  y_meta;
  logic [NIB_W-1:0]  y_s;
  logic [NUM_PB-1:0] mask_next;

  assign pb_raw = {pb4, pb3, pb2, pb1};

  for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
    pb_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb (
      .clk        (clk),
      .rst        (rst),
      .raw        (pb_raw[i]),
      .press_pulse(strobe[i]),
      .level      (unused_level[i])
    );
  end

  // clr wipes history first so a coincident strobe still records its field.
  // NOTE: combinational logic gets a full assignment on every path so no
  // latch is inferred.
  always_comb begin
    mask_next = (clr ? '0 : load_mask) | strobe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta         <= '0;
      y_s            <= '0;
      a              <= '0;
      b              <= '0;
      load_mask      <= '0;
      operands_valid <= 1'b0;
      upd            <= 1'b0;
    end else begin
      y_meta <= y;
      y_s    <= y_meta;
      if (strobe[FLD_A_LO]) a[NIB_W-1:0]    <= y_s;
      if (strobe[FLD_A_HI]) a[OP_W-1:NIB_W] <= y_s[HI_W-1:0];
      if (strobe[FLD_B_LO]) b[NIB_W-1:0]    <= y_s;
      if (strobe[FLD_B_HI]) b[OP_W-1:NIB_W] <= y_s[HI_W-1:0];
      load_mask      <= mask_next;
      operands_valid <= &mask_next;
      upd            <= |strobe;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window (4 cycles),
// so a press edge shows up on upd exactly 7 clocks later.
module tb_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] y;
  logic       clr;
  logic [6:0] a;
  logic [6:0] b;
  logic [3:0] load_mask;
  logic       operands_valid;
  logic       upd;

  int n_cmp = 0;
  int n_err = 0;

  operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pb1           (pb[0]),
    .pb2           (pb[1]),
    .pb3           (pb[2]),
    .pb4           (pb[3]),
    .y             (y),
    .clr           (clr),
    .a             (a),
    .b             (b),
    .load_mask     (load_mask),
    .operands_valid(operands_valid),
    .upd           (upd)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present yv, press button idx for 12 cycles, release for 10 cycles.
  task automatic press_hold(input int idx, input logic [3:0] yv,
                            output int pulses, output int first_cyc,
                            output logic valid_at_upd);
    pulses = 0; first_cyc = 0; valid_at_upd = 1'b0;
    y = yv;
    repeat (3) tick();
    pb[idx] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      if (c == 13) pb[idx] = 1'b0;
      tick();
      if (upd === 1'b1) begin
        pulses++;
        if (first_cyc == 0) begin
          first_cyc    = c;
          valid_at_upd = operands_valid;
        end
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1; pb = '0; y = '0; clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (a !== 7'h00) begin n_err++; $display("FAIL reset_a: got %h want 00", a); end
    n_cmp++; if (b !== 7'h00) begin n_err++; $display("FAIL reset_b: got %h want 00", b); end
    n_cmp++; if (load_mask !== 4'b0000) begin n_err++; $display("FAIL reset_mask: got %b want 0000", load_mask); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", operands_valid); end
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (upd !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL idle_upd: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_single_press();
    int pulses, first_cyc;
    y = 4'hA;
    repeat (3) tick();
    pb[0] = 1'b1;
    pulses = 0; first_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (upd === 1'b1) begin
        pulses++;
        if (first_cyc == 0) first_cyc = c;
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL press_pulses: got %0d want 1", pulses); end
    n_cmp++; if (first_cyc != 7) begin n_err++; $display("FAIL press_latency: got %0d want 7", first_cyc); end
    n_cmp++; if (a !== 7'h0A) begin n_err++; $display("FAIL press_a: got %h want 0a", a); end
    n_cmp++; if (load_mask !== 4'b0001) begin n_err++; $display("FAIL press_mask: got %b want 0001", load_mask); end
    pb[0] = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (upd !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL release_upd: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_full_load();
    int pulses, first_cyc;
    logic v;
    press_hold(0, 4'h5, pulses, first_cyc, v);
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL load_pb1_pulses: got %0d want 1", pulses); end
    press_hold(1, 4'h3, pulses, first_cyc, v);
    n_cmp++; if (a !== 7'h35) begin n_err++; $display("FAIL load_a: got %h want 35", a); end
    press_hold(2, 4'hF, pulses, first_cyc, v);
    n_cmp++; if (load_mask !== 4'b0111) begin n_err++; $display("FAIL load_mask3: got %b want 0111", load_mask); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_err++; $display("FAIL load_valid3: got %b want 0", operands_valid); end
    press_hold(3, 4'hE, pulses, first_cyc, v);
    n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL valid_with_upd: got %b want 1", v); end
    n_cmp++; if (first_cyc != 7) begin n_err++; $display("FAIL pb4_latency: got %0d want 7", first_cyc); end
    n_cmp++; if (b !== 7'h6F) begin n_err++; $display("FAIL load_b: got %h want 6f", b); end
    n_cmp++; if (load_mask !== 4'b1111) begin n_err++; $display("FAIL load_mask4: got %b want 1111", load_mask); end
  endtask

  task automatic test_bounce();
    int pulses;
    y = 4'h1;
    repeat (3) tick();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      pb[2] = (c % 2 == 0);
      tick();
      if (upd !== 1'b0) pulses++;
    end
    pb[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (upd !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL bounce_upd: got %0d pulses want 0", pulses); end
    n_cmp++; if (b !== 7'h6F) begin n_err++; $display("FAIL bounce_b: got %h want 6f", b); end
    pulses = 0;
    pb[2] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) pb[2] = 1'b0;
      tick();
      if (upd !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL short_upd: got %0d pulses want 0", pulses); end
    n_cmp++; if (b !== 7'h6F) begin n_err++; $display("FAIL short_b: got %h want 6f", b); end
  endtask

  task automatic test_simultaneous();
    int pulses, first_cyc;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (load_mask !== 4'b0000) begin n_err++; $display("FAIL clr_mask: got %b want 0000", load_mask); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b want 0", operands_valid); end
    n_cmp++; if (a !== 7'h35) begin n_err++; $display("FAIL clr_keeps_a: got %h want 35", a); end
    y = 4'h7;
    repeat (3) tick();
    pb[1] = 1'b1; pb[3] = 1'b1;
    pulses = 0; first_cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (upd === 1'b1) begin
        pulses++;
        if (first_cyc == 0) first_cyc = c;
      end
    end
    pb[1] = 1'b0; pb[3] = 1'b0;
    repeat (10) tick();
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL simul_pulses: got %0d want 1", pulses); end
    n_cmp++; if (first_cyc != 7) begin n_err++; $display("FAIL simul_latency: got %0d want 7", first_cyc); end
    n_cmp++; if (a !== 7'h75) begin n_err++; $display("FAIL simul_a: got %h want 75", a); end
    n_cmp++; if (b !== 7'h7F) begin n_err++; $display("FAIL simul_b: got %h want 7f", b); end
    n_cmp++; if (load_mask !== 4'b1010) begin n_err++; $display("FAIL simul_mask: got %b want 1010", load_mask); end
  endtask

  task automatic test_clr_with_strobe();
    int pulses, first_cyc;
    logic v;
    press_hold(0, 4'h5, pulses, first_cyc, v);
    press_hold(2, 4'hF, pulses, first_cyc, v);
    n_cmp++; if (operands_valid !== 1'b1) begin n_err++; $display("FAIL all_valid: got %b want 1", operands_valid); end
    y = 4'h5;
    repeat (3) tick();
    pb[0] = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (upd !== 1'b1) begin n_err++; $display("FAIL clrstb_upd: got %b want 1", upd); end
    n_cmp++; if (load_mask !== 4'b0001) begin n_err++; $display("FAIL clrstb_mask: got %b want 0001", load_mask); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_err++; $display("FAIL clrstb_valid: got %b want 0", operands_valid); end
    n_cmp++; if (a !== 7'h75) begin n_err++; $display("FAIL clrstb_a: got %h want 75", a); end
    n_cmp++; if (b !== 7'h7F) begin n_err++; $display("FAIL clrstb_b: got %h want 7f", b); end
    pb[0] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int pulses, first_cyc;
    y = 4'h3;
    repeat (3) tick();
    pb[2] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (a !== 7'h00) begin n_err++; $display("FAIL rstmid_a: got %h want 00", a); end
    n_cmp++; if (b !== 7'h00) begin n_err++; $display("FAIL rstmid_b: got %h want 00", b); end
    n_cmp++; if (load_mask !== 4'b0000) begin n_err++; $display("FAIL rstmid_mask: got %b want 0000", load_mask); end
    n_cmp++; if (operands_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", operands_valid); end
    n_cmp++; if (upd !== 1'b0) begin n_err++; $display("FAIL rstmid_upd: got %b want 0", upd); end
    tick();
    rst = 1'b0;
    pulses = 0; first_cyc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (upd === 1'b1) begin
        pulses++;
        if (first_cyc == 0) first_cyc = c;
      end
    end
    pb[2] = 1'b0;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL held_pulses: got %0d want 1", pulses); end
    n_cmp++; if (first_cyc != 7) begin n_err++; $display("FAIL held_latency: got %0d want 7", first_cyc); end
    n_cmp++; if (b !== 7'h03) begin n_err++; $display("FAIL held_b: got %h want 03", b); end
    n_cmp++; if (load_mask !== 4'b0100) begin n_err++; $display("FAIL held_mask: got %b want 0100", load_mask); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_full_load();
    test_bounce();
    test_simultaneous();
    test_clr_with_strobe();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
